uart_time_set_rx: RTL and testbench

- Serial time-set input path for the alarm clock.
- Receives 8N1 UART bytes and parses ASCII commands of the form `T`HHMM<CR|LF> (set clock) or `A`HHMM<CR|LF> (set alarm).
- Validates each field as 24-hour BCD. On success, drives a 16-bit BCD value plus a one-cycle load strobe into the clock/alarm register block, alongside the existing button-based load path.

---
 rtl/uart_time_set_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_time_set_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_time_set_rx.sv
// uart_time_set_rx: 8N1 UART receiver plus ASCII command parser for the
// alarm clock. Accepts "T"HHMM<CR|LF> (set clock) and "A"HHMM<CR|LF> (set
// alarm). Digits are checked as 24-hour BCD and committed with a one-cycle
// load strobe.
// Optional build macro: CMD_TIMEOUT_EN adds an inter-byte timeout that
// abandons a half-received command after TIMEOUT_CYC idle cycles.
module uart_time_set_rx #(
  parameter int CLK_HZ      = 100000000,
  parameter int BAUD        = 9600,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] time_val,
  output logic        clock_set,
  output logic        alarm_set,
  output logic        cmd_err,
  output logic        rx_busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_D0   = 3'd1;
  localparam logic [2:0] P_D1   = 3'd2;
  localparam logic [2:0] P_D2   = 3'd3;
  localparam logic [2:0] P_D3   = 3'd4;
  localparam logic [2:0] P_END  = 3'd5;

  logic          rx_s1_q, rx_s2_q;
  logic [1:0]    r_state_q, r_state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          byte_vld_q, byte_vld_d;
  logic          frame_err;

  logic [2:0]    p_state_q, p_state_d;
  logic          tgt_q, tgt_d;          // 0 = clock, 1 = alarm
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   time_val_q, time_val_d;
  logic          clock_set_q, clock_set_d;
  logic          alarm_set_q, alarm_set_d;
  logic          cmd_err_q;
  logic          rx_busy_q;
  logic          parse_err;
  logic          digit_ok;
  logic [3:0]    dig;
  logic          timeout;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // UART frame receiver: start qualify at half bit, then sample mid-bit
  always_comb begin
    r_state_d  = r_state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    byte_vld_d = 1'b0;
    frame_err  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        baud_cnt_d = '0;
        if (!rx_s2_q) r_state_d = R_START;
      end
      R_START: begin
        if (baud_cnt_q == HALF_M1) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          r_state_d  = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (baud_cnt_q == FULL_M1) begin
          baud_cnt_d = '0;
          shreg_d    = {rx_s2_q, shreg_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) r_state_d = R_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin  // R_STOP
        if (baud_cnt_q == FULL_M1) begin
          baud_cnt_d = '0;
          r_state_d  = R_IDLE;
          if (rx_s2_q) byte_vld_d = 1'b1;
          else         frame_err  = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign dig      = shreg_q[3:0];
  assign digit_ok = (shreg_q[7:4] == 4'h3) && (dig <= 4'd9);

  // Command parser: digits go to a shadow register, time_val only on commit
  always_comb begin
    p_state_d   = p_state_q;
    tgt_d       = tgt_q;
    shadow_d    = shadow_q;
    time_val_d  = time_val_q;
    clock_set_d = 1'b0;
    alarm_set_d = 1'b0;
    parse_err   = 1'b0;
    if (byte_vld_q) begin
      case (p_state_q)
        P_IDLE: begin
          if (shreg_q == 8'h54 || shreg_q == 8'h74) begin
            tgt_d     = 1'b0;
            p_state_d = P_D0;
          end else if (shreg_q == 8'h41 || shreg_q == 8'h61) begin
            tgt_d     = 1'b1;
            p_state_d = P_D0;
          end
        end
        P_D0: begin
          if (digit_ok && dig <= 4'd2) begin
            shadow_d[15:12] = dig;
            p_state_d       = P_D1;
          end else parse_err = 1'b1;
        end
        P_D1: begin
          if (digit_ok && (shadow_q[15:12] != 4'd2 || dig <= 4'd3)) begin
            shadow_d[11:8] = dig;
            p_state_d      = P_D2;
          end else parse_err = 1'b1;
        end
        P_D2: begin
          if (digit_ok && dig <= 4'd5) begin
            shadow_d[7:4] = dig;
            p_state_d     = P_D3;
          end else parse_err = 1'b1;
        end
        P_D3: begin
          if (digit_ok) begin
            shadow_d[3:0] = dig;
            p_state_d     = P_END;
          end else parse_err = 1'b1;
        end
        P_END: begin
          if (shreg_q == 8'h0D || shreg_q == 8'h0A) begin
            time_val_d  = shadow_q;
            clock_set_d = !tgt_q;
            alarm_set_d = tgt_q;
            p_state_d   = P_IDLE;
          end else parse_err = 1'b1;
        end
        default: p_state_d = P_IDLE;
      endcase
    end
    // The offending byte is dropped, never re-read as a command letter
    if (parse_err || timeout) p_state_d = P_IDLE;
  end

`ifdef CMD_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  assign timeout = (p_state_q != P_IDLE) && !byte_vld_q &&
                   (to_cnt_q == 32'(TIMEOUT_CYC - 1));

  // Inter-byte idle counter, only running while a command is open
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else if (byte_vld_q || p_state_q == P_IDLE || timeout) to_cnt_q <= '0;
    else to_cnt_q <= to_cnt_q + 32'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q   <= R_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      byte_vld_q  <= 1'b0;
      p_state_q   <= P_IDLE;
      tgt_q       <= 1'b0;
      shadow_q    <= '0;
      time_val_q  <= '0;
      clock_set_q <= 1'b0;
      alarm_set_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      byte_vld_q  <= byte_vld_d;
      p_state_q   <= p_state_d;
      tgt_q       <= tgt_d;
      shadow_q    <= shadow_d;
      time_val_q  <= time_val_d;
      clock_set_q <= clock_set_d;
      alarm_set_q <= alarm_set_d;
      cmd_err_q   <= frame_err | parse_err | timeout;
      rx_busy_q   <= (r_state_q != R_IDLE) || (p_state_q != P_IDLE);
    end
  end

  assign time_val  = time_val_q;
  assign clock_set = clock_set_q;
  assign alarm_set = alarm_set_q;
  assign cmd_err   = cmd_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_time_set_rx.sv
// Bench for uart_time_set_rx: drives UART frames, queues expected strobes,
// and a negedge monitor pops and compares every strobe the DUT raises.
module tb_uart_time_set_rx;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;

  localparam logic [2:0] EV_CLK = 3'b100;
  localparam logic [2:0] EV_ALM = 3'b010;
  localparam logic [2:0] EV_ERR = 3'b001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] time_val;
  logic        clock_set, alarm_set, cmd_err, rx_busy;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] val;
  } evt_t;

  evt_t        sb[$];
  logic [15:0] model_tv = 16'h0000;
  int          n_vec  = 0;
  int          n_miss = 0;

  uart_time_set_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(5000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .time_val  (time_val),
    .clock_set (clock_set),
    .alarm_set (alarm_set),
    .cmd_err   (cmd_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [2:0] kind, input logic [15:0] val);
    evt_t e;
    if (kind != EV_ERR) model_tv = val;
    e.kind = kind;
    e.val  = model_tv;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1,
                           input bit rst_at_b4 = 1'b0);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (rst_at_b4 && i == 4) begin
        tick(DIV / 2);
        rst = 1'b1;
        #1;
        chk("rst_tv",    time_val,  16'h0000);
        chk("rst_cset",  clock_set, 1'b0);
        chk("rst_aset",  alarm_set, 1'b0);
        chk("rst_err",   cmd_err,   1'b0);
        chk("rst_busy",  rx_busy,   1'b0);
        model_tv = 16'h0000;
        tick(DIV / 2);
        rst = 1'b0;
      end else begin
        tick(DIV);
      end
    end
    rx = stop_v;
    tick(DIV);
    rx = 1'b1;
    tick(DIV);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && (clock_set || alarm_set || cmd_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_evt", {clock_set, alarm_set, cmd_err}, 3'b000);
      end else begin
        evt_t e;
        e = sb.pop_front();
        chk("evt_kind", {clock_set, alarm_set, cmd_err}, e.kind);
        chk("evt_tv",   time_val, e.val);
      end
    end
  end

  initial begin
    #1;
    chk("init_tv",   time_val,  16'h0000);
    chk("init_cset", clock_set, 1'b0);
    chk("init_aset", alarm_set, 1'b0);
    chk("init_err",  cmd_err,   1'b0);
    chk("init_busy", rx_busy,   1'b0);
    tick(3);
    rst = 1'b0;
    tick(4);

    // Basic clock set, busy while command is open
    expect_evt(EV_CLK, 16'h1234);
    send_str("T");
    chk("busy_open", rx_busy, 1'b1);
    send_str("1234\r");
    tick(DIV);
    chk("busy_done", rx_busy, 1'b0);
    chk("tv_1234", time_val, 16'h1234);

    // Alarm set, then out-of-range hour keeps previous value
    expect_evt(EV_ALM, 16'h0630);
    send_str("a0630\n");
    expect_evt(EV_ERR, 16'h0);
    send_str("T2400\r");
    chk("tv_hold_0630", time_val, 16'h0630);

    // Bad character aborts; the next letter starts a fresh command
    expect_evt(EV_ERR, 16'h0);
    expect_evt(EV_CLK, 16'h1159);
    send_str("T1X");
    send_str("T1159\r");
    chk("tv_1159", time_val, 16'h1159);

    // Framing error mid-command leaves parser where it was
    send_str("T12");
    expect_evt(EV_ERR, 16'h0);
    send_byte(8'h55, 1'b0);
    expect_evt(EV_CLK, 16'h1234);
    send_str("34\r");
    chk("tv_frame", time_val, 16'h1234);

    // Reset in the middle of a byte wipes the command
    send_str("T12");
    send_byte("3", 1'b1, 1'b1);
    tick(12 * DIV);
    chk("post_rst_tv", time_val, 16'h0000);
    expect_evt(EV_CLK, 16'h0000);
    send_str("T0000\r");

    // Range boundaries and terminator checks
    expect_evt(EV_CLK, 16'h2359);
    send_str("T2359\r");
    expect_evt(EV_ERR, 16'h0);
    send_str("A1960\r");
    expect_evt(EV_ERR, 16'h0);
    send_str("T:00\r");
    expect_evt(EV_ERR, 16'h0);
    send_str("T3");
    expect_evt(EV_ERR, 16'h0);
    send_str("T12345\r");
    chk("tv_hold_2359", time_val, 16'h2359);
    expect_evt(EV_CLK, 16'h0959);
    send_str("t0959\n");
    expect_evt(EV_ALM, 16'h2000);
    send_str("A2000\r");

    // Short glitch must not produce a byte
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * DIV);
    chk("glitch_busy", rx_busy, 1'b0);

`ifdef CMD_TIMEOUT_EN
    send_str("T12");
    expect_evt(EV_ERR, 16'h0);
    tick(6000);
    send_str("34\r");
    chk("tv_timeout", time_val, 16'h2000);
`endif

    tick(4 * DIV);
    chk("sb_drain", sb.size(), 0);
    chk("final_busy", rx_busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
